cacheline_adaptor: RTL and testbench
====================================

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameter: s_offset, default 5, log2 of line size in bytes (line = 8*2^s_offset bits = 256).
REQ-002 Parameter: s_beat, default 64, burst beat width in bits; must divide line width; beats N = line/s_beat (default 4).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 line_i  input  line  cache line to write back (cache side).
REQ-006 line_o  output  line  assembled fill line (cache side, feeds data array datain).
REQ-007 address_i  input  32  cache-side byte address of request.
REQ-008 read_i  input  1  cache-side line fill request.
REQ-009 write_i  input  1  cache-side line writeback request.
REQ-010 resp_o  output  1  one-cycle completion pulse to cache.
REQ-011 burst_i  input  s_beat  memory read beat.
REQ-012 burst_o  output  s_beat  memory write beat.
REQ-013 address_o  output  32  line-aligned memory address.
REQ-014 read_o  output  1  memory burst read request.
REQ-015 write_o  output  1  memory burst write request.
REQ-016 resp_i  input  1  memory beat strobe; one beat per cycle asserted.

Function
REQ-017 States: IDLE, RD_BURST, WR_BURST, DONE; 2-bit state, beat counter of clog2(N) bits.
REQ-018 IDLE: write_i=1 -> latch line_i, address_o <= {address_i[31:s_offset], s_offset'b0}, count<=0, go WR_BURST; write_i takes priority over simultaneous read_i.
REQ-019 IDLE: read_i=1 and write_i=0 -> latch aligned address, count<=0, go RD_BURST.
REQ-020 IDLE: resp_i ignored; read_i/write_i ignored in every state other than IDLE.
REQ-021 read_o=1 exactly while state=RD_BURST; write_o=1 exactly while state=WR_BURST (registered-state decode, first asserted the cycle after acceptance).
REQ-022 RD_BURST: each cycle with resp_i=1, line_o[count*s_beat +: s_beat] <= burst_i, count <= count+1; cycles with resp_i=0 hold all state (stall allowed between beats).
REQ-023 RD_BURST: beat with count=N-1 and resp_i=1 -> go DONE.
REQ-024 WR_BURST: burst_o = latched_line[count*s_beat +: s_beat] combinationally; resp_i=1 -> count <= count+1; beat N-1 accepted -> go DONE.
REQ-025 burst_o outside WR_BURST = 0.
REQ-026 DONE: resp_o=1 for exactly one cycle, read_o=write_o=0; unconditional return to IDLE next edge.
REQ-027 Latency with back-to-back resp_i: request sampled at edge 0, beats at edges 1..N, resp_o high during cycle N+1 (N+2 cycles request-to-response).
REQ-028 line_o holds last filled line until the next RD_BURST overwrites beats; unchanged by writebacks.
REQ-029 Counter wraps to 0 after beat N-1; no beat beyond N captured or driven per request.
REQ-030 address_o holds its value from acceptance until next acceptance.

Reset
REQ-031 rst=0 forces state IDLE, count 0, line_o 0, latched line 0, address_o 0, resp_o 0, read_o 0, write_o 0, burst_o 0, immediately and independent of clk.
REQ-032 Reset mid-burst abandons the transaction; no resp_o pulse issued; first post-reset edge with rst=1 evaluates IDLE rules.

Verification
REQ-033 Fill: read_i, address_i=0x1234_5678, resp_i 4 cycles with burst_i=A,B,C,D -> address_o=0x1234_5660, read_o 4 cycles, line_o={D,C,B,A}, resp_o one pulse at cycle 6.
REQ-034 Writeback: write_i, line_i={W3,W2,W1,W0}, resp_i continuous -> burst_o W0,W1,W2,W3 on successive cycles, write_o 4 cycles, resp_o one pulse.
REQ-035 Stall: fill with resp_i pattern 1,0,0,1,1,0,1 -> beats land in order 0..3 only on resp_i cycles, resp_o after 4th beat.
REQ-036 Priority: read_i=write_i=1 in IDLE -> WR_BURST entered, read_o stays 0 throughout.
REQ-037 Reset mid-burst: rst=0 after 2 fill beats -> all outputs 0 immediately, no resp_o; subsequent fill completes correctly with count from 0.
REQ-038 Spurious: resp_i=1 in IDLE and read_i toggled during WR_BURST -> no state change, no line_o update.

Source files
------------

// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_adaptor
// Purpose  : Bridges whole-line cache fills/writebacks to a beat-wise memory burst.
// Revision : 1.0 - initial release
// ============================================================================
module cacheline_adaptor #(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_beat   = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [(8<<s_offset)-1:0]   line_i,
  output logic [(8<<s_offset)-1:0]   line_o,
  input  logic [31:0]                address_i,
  input  logic                       read_i,
  input  logic                       write_i,
  output logic                       resp_o,
  input  logic [s_beat-1:0]          burst_i,
  output logic [s_beat-1:0]          burst_o,
  output logic [31:0]                address_o,
  output logic                       read_o,
  output logic                       write_o,
  input  logic                       resp_i
);

  localparam int unsigned C_LINE_W = 8 << s_offset;
  localparam int unsigned C_BEATS  = C_LINE_W / s_beat;
  localparam int unsigned C_CNT_W  = (C_BEATS > 1) ? $clog2(C_BEATS) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(C_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [C_CNT_W-1:0] r_count;
  logic [s_beat-1:0]  r_wline [C_BEATS];
  logic [s_beat-1:0]  r_fill  [C_BEATS];
  logic               w_accept_rd;
  logic               w_accept_wr;
  logic               w_beat;
  logic               w_unused;

  // Byte offset within the line never reaches memory.
  assign w_unused = ^address_i[s_offset-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept_rd  = 1'b0;
    w_accept_wr  = 1'b0;
    w_beat       = 1'b0;
    read_o       = 1'b0;
    write_o      = 1'b0;
    resp_o       = 1'b0;
    case (r_state)
      IDLE: begin
        if (write_i) begin
          w_accept_wr  = 1'b1;
          w_state_next = WR_BURST;
        end else if (read_i) begin
          w_accept_rd  = 1'b1;
          w_state_next = RD_BURST;
        end
      end
      RD_BURST: begin
        read_o = 1'b1;
        w_beat = resp_i;
        if (resp_i && (r_count == C_LAST)) w_state_next = DONE;
      end
      WR_BURST: begin
        write_o = 1'b1;
        w_beat  = resp_i;
        if (resp_i && (r_count == C_LAST)) w_state_next = DONE;
      end
      DONE: begin
        resp_o       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count   <= '0;
      address_o <= '0;
      for (int unsigned i = 0; i < C_BEATS; i++) begin
        r_wline[i] <= '0;
        r_fill[i]  <= '0;
      end
    end else begin
      if (w_accept_rd || w_accept_wr) begin
        address_o <= {address_i[31:s_offset], {s_offset{1'b0}}};
        r_count   <= '0;
      end
      if (w_accept_wr) begin
        for (int unsigned i = 0; i < C_BEATS; i++) begin
          r_wline[i] <= line_i[i*s_beat +: s_beat];
        end
      end
      if (w_beat) begin
        r_count <= (r_count == C_LAST) ? '0 : r_count + C_CNT_W'(1);
      end
      // Fill beats land only in the slot addressed by the current beat count.
      if (w_beat && (r_state == RD_BURST)) begin
        for (int unsigned i = 0; i < C_BEATS; i++) begin
          if (r_count == C_CNT_W'(i)) r_fill[i] <= burst_i;
        end
      end
    end
  end

  assign burst_o = (r_state == WR_BURST) ? r_wline[r_count] : '0;

  for (genvar g = 0; g < C_BEATS; g++) begin : g_pack
    assign line_o[g*s_beat +: s_beat] = r_fill[g];
  end

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : tb_cacheline_adaptor
// Purpose  : Self-checking bench: directed vector table, corner sequences, random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cacheline_adaptor;

  localparam int OFF  = 5;
  localparam int BEAT = 64;
  localparam int LW   = 256;
  localparam int N    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [LW-1:0]   line_i;
  logic [LW-1:0]   line_o;
  logic [31:0]     address_i;
  logic            read_i;
  logic            write_i;
  logic            resp_o;
  logic [BEAT-1:0] burst_i;
  logic [BEAT-1:0] burst_o;
  logic [31:0]     address_o;
  logic            read_o;
  logic            write_o;
  logic            resp_i;

  cacheline_adaptor #(.s_offset(OFF), .s_beat(BEAT)) dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic [LW-1:0] model_line;

  typedef struct {
    logic          rd;
    logic          wr;
    logic          tog;
    logic [31:0]   addr;
    logic [LW-1:0] data;
    logic [7:0]    pat;
    logic [31:0]   exp_addr;
    logic [LW-1:0] exp_line;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".resp_o"},  resp_o,  1'b0);
    chk({tag, ".read_o"},  read_o,  1'b0);
    chk({tag, ".write_o"}, write_o, 1'b0);
    chk({tag, ".burst_o"}, burst_o, '0);
  endtask

  // One request: beats are taken from data (beat k = data[k*BEAT +: BEAT]);
  // pat gives resp_i for the first 8 burst cycles, then resp_i stays high.
  task automatic run_txn(input logic rd, input logic wr, input logic tog,
                         input logic [31:0] addr, input logic [LW-1:0] data,
                         input logic [7:0] pat, input logic [31:0] exp_addr,
                         input logic [LW-1:0] exp_line);
    int   k;
    int   cyc;
    logic r;
    read_i    = rd;
    write_i   = wr;
    address_i = addr;
    line_i    = data;
    step();
    read_i    = 1'b0;
    write_i   = 1'b0;
    address_i = $urandom;
    line_i    = {8{$urandom}};
    k   = 0;
    cyc = 0;
    while (k < N && cyc < 40) begin
      chk("burst.read_o",  read_o,  !wr);
      chk("burst.write_o", write_o, wr);
      chk("burst.resp_o",  resp_o,  1'b0);
      chk("burst.address_o", address_o, exp_addr);
      if (wr) begin
        chk("burst.burst_o", burst_o, data[k*BEAT +: BEAT]);
        chk("burst.line_o_hold", line_o, model_line);
      end else begin
        chk("burst.burst_o_zero", burst_o, '0);
      end
      r = (cyc < 8) ? pat[cyc] : 1'b1;
      resp_i  = r;
      burst_i = (r && !wr) ? data[k*BEAT +: BEAT] : {$urandom, $urandom};
      read_i  = tog ? cyc[0] : 1'b0;
      step();
      if (r) k++;
      cyc++;
    end
    if (k < N) begin
      vectors++;
      miscompares++;
      $display("FAIL burst_timeout: got %0d beats expected %0d", k, N);
    end
    resp_i = 1'b0;
    read_i = 1'b0;
    chk("done.resp_o",  resp_o,  1'b1);
    chk("done.read_o",  read_o,  1'b0);
    chk("done.write_o", write_o, 1'b0);
    chk("done.burst_o", burst_o, '0);
    step();
    chk_idle("after");
    chk("after.line_o",    line_o,    exp_line);
    chk("after.address_o", address_o, exp_addr);
    model_line = exp_line;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [LW-1:0] d;
    logic [31:0]   a;
    logic          rd, wr;
    int            op;

    vt[0] = '{rd:1'b1, wr:1'b0, tog:1'b0, addr:32'h1234_5678,
              data:{64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003, 64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001},
              pat:8'hFF, exp_addr:32'h1234_5660,
              exp_line:{64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003, 64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001}};
    vt[1] = '{rd:1'b0, wr:1'b1, tog:1'b1, addr:32'h0000_0040,
              data:{64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111, 64'h0F0F_0F0F_0F0F_0F0F},
              pat:8'hFF, exp_addr:32'h0000_0040,
              exp_line:{64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003, 64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001}};
    vt[2] = '{rd:1'b1, wr:1'b0, tog:1'b0, addr:32'hFFFF_FFFF,
              data:{64'hE3E3_E3E3_0000_0000, 64'hE2E2_0000_E2E2_0000, 64'hE1E1_0000_0000_E1E1, 64'hE0E0_FFFF_FFFF_E0E0},
              pat:8'h59, exp_addr:32'hFFFF_FFE0,
              exp_line:{64'hE3E3_E3E3_0000_0000, 64'hE2E2_0000_E2E2_0000, 64'hE1E1_0000_0000_E1E1, 64'hE0E0_FFFF_FFFF_E0E0}};
    vt[3] = '{rd:1'b1, wr:1'b1, tog:1'b0, addr:32'h8000_001F,
              data:{64'h5A5A_5A5A_5A5A_5A5A, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210},
              pat:8'hA5, exp_addr:32'h8000_0000,
              exp_line:{64'hE3E3_E3E3_0000_0000, 64'hE2E2_0000_E2E2_0000, 64'hE1E1_0000_0000_E1E1, 64'hE0E0_FFFF_FFFF_E0E0}};
    vt[4] = '{rd:1'b1, wr:1'b0, tog:1'b0, addr:32'h0000_0020,
              data:{64'h0000_0000_0000_0008, 64'h0000_0000_0000_0007, 64'h0000_0000_0000_0006, 64'h0000_0000_0000_0005},
              pat:8'h01, exp_addr:32'h0000_0020,
              exp_line:{64'h0000_0000_0000_0008, 64'h0000_0000_0000_0007, 64'h0000_0000_0000_0006, 64'h0000_0000_0000_0005}};

    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = '0; line_i = '0; burst_i = '0;
    model_line = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk_idle("reset");
    chk("reset.line_o",    line_o,    '0);
    chk("reset.address_o", address_o, '0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk_idle("post_reset");

    for (int i = 0; i < 5; i++) begin
      run_txn(vt[i].rd, vt[i].wr, vt[i].tog, vt[i].addr, vt[i].data,
              vt[i].pat, vt[i].exp_addr, vt[i].exp_line);
    end

    // Spurious memory strobes while idle must not disturb anything.
    for (int i = 0; i < 3; i++) begin
      resp_i  = 1'b1;
      burst_i = {$urandom, $urandom};
      step();
      chk_idle("spurious");
      chk("spurious.line_o", line_o, model_line);
    end
    resp_i = 1'b0;

    // Reset two beats into a fill.
    read_i = 1'b1; address_i = 32'h0000_1000;
    step();
    read_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      resp_i  = 1'b1;
      burst_i = 64'hC0FF_EE00_0000_0000 | 64'(i + 1);
      step();
    end
    resp_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_idle("midrst");
    chk("midrst.line_o",    line_o,    '0);
    chk("midrst.address_o", address_o, '0);
    model_line = '0;
    step();
    chk_idle("midrst_hold");
    @(negedge clk);
    rst = 1'b1;
    step();
    chk_idle("midrst_release");
    run_txn(1'b1, 1'b0, 1'b0, 32'h0000_1004,
            {64'h4444_0000_0000_0000, 64'h3333_0000_0000_0000, 64'h2222_0000_0000_0000, 64'h1111_0000_0000_0000},
            8'hFF, 32'h0000_1000,
            {64'h4444_0000_0000_0000, 64'h3333_0000_0000_0000, 64'h2222_0000_0000_0000, 64'h1111_0000_0000_0000});

    // Random traffic against the transaction-level model.
    for (int t = 0; t < 30; t++) begin
      op = $urandom_range(0, 2);
      rd = (op != 1);
      wr = (op != 0);
      a  = $urandom;
      for (int b = 0; b < LW / 32; b++) d[b*32 +: 32] = $urandom;
      run_txn(rd, wr, 1'($urandom), a, d, 8'($urandom_range(0, 255)),
              a & 32'hFFFF_FFE0, wr ? model_line : d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
